// File: rtl/l1icache_control.sv
// Sequencing FSM for a 2-way set-associative L1 instruction cache (hit/miss, refill, LRU).
// Latency: hits respond in the request cycle; misses respond 2 cycles plus the pmem wait after miss detect.
// Backpressure: the IF stage holds mem_read/address until mem_resp; pmem_read is held until pmem_resp.
//
// Ports:
//   clk, rst_n              - clock, asynchronous active-low reset
//   mem_read / mem_resp     - IF-stage fetch request / completion
//   hit0, hit1, lru_out     - per-way hit and LRU victim bit from the external arrays
//   pmem_read / pmem_resp   - line-fill request / single-cycle line-ready pulse
//   ld_tag/ld_valid/ld_data - array load strobes; target way is fill_way
//   ld_lru, lru_in          - LRU array write strobe and value
//   hit_way                 - data output mux select
//   hit_count, miss_count   - saturating performance counters
module l1icache_control #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mem_read,
  input  logic                 hit0,
  input  logic                 hit1,
  input  logic                 lru_out,
  input  logic                 pmem_resp,
  output logic                 mem_resp,
  output logic                 pmem_read,
  output logic                 ld_tag,
  output logic                 ld_valid,
  output logic                 ld_data,
  output logic                 fill_way,
  output logic                 ld_lru,
  output logic                 lru_in,
  output logic                 hit_way,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count
);

  typedef enum logic [1:0] {
    S_CHECK  = 2'd0,
    S_FETCH  = 2'd1,
    S_REFILL = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  state_t               state_q, state_d;
  logic                 fill_way_q, fill_way_d;
  logic [CNT_WIDTH-1:0] hit_count_q, hit_count_d;
  logic [CNT_WIDTH-1:0] miss_count_q, miss_count_d;

  logic any_hit;
  // A simultaneous hit on both ways (duplicate tag) is resolved as a way0 hit.
  assign any_hit = hit0 | hit1;

  always_comb begin
    state_d      = state_q;
    fill_way_d   = fill_way_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    ld_tag       = 1'b0;
    ld_valid     = 1'b0;
    ld_data      = 1'b0;
    ld_lru       = 1'b0;
    lru_in       = 1'b0;
    // Mux select is only meaningful on a hit; way0 wins a double hit.
    hit_way      = hit1 & ~hit0;

    unique case (state_q)
      S_CHECK: begin
        if (mem_read) begin
          if (any_hit) begin
            mem_resp = 1'b1;
            ld_lru   = 1'b1;
            // Point the victim at the way that was not just used.
            lru_in   = hit0;
            if (hit_count_q != CNT_MAX) hit_count_d = hit_count_q + CNT_ONE;
          end else begin
            // Victim is latched here so the load logic sees a stable way for
            // the whole refill, even if the LRU array output changes.
            fill_way_d = lru_out;
            if (miss_count_q != CNT_MAX) miss_count_d = miss_count_q + CNT_ONE;
            state_d    = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          ld_tag   = 1'b1;
          ld_valid = 1'b1;
          ld_data  = 1'b1;
          state_d  = S_REFILL;
        end
      end
      S_REFILL: begin
        // One settle cycle so the arrays present the new line before the
        // held request is re-checked (and then hits).
        state_d = S_CHECK;
      end
      default: begin
        state_d = S_CHECK;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_CHECK;
      fill_way_q   <= 1'b0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      fill_way_q   <= fill_way_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign fill_way   = fill_way_q;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule

// File: tb/tb_l1icache_control.sv
// Directed bench for l1icache_control: hits, miss/refill, flush, async reset, counter saturation.
// A second instance with 4-bit counters shares all inputs and is used for the saturation step.
module tb_l1icache_control;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        mem_read = 1'b0;
  logic        hit0 = 1'b0;
  logic        hit1 = 1'b0;
  logic        lru_out = 1'b0;
  logic        pmem_resp = 1'b0;

  logic        mem_resp, pmem_read, ld_tag, ld_valid, ld_data;
  logic        fill_way, ld_lru, lru_in, hit_way;
  logic [31:0] hit_count, miss_count;

  logic        s_mem_resp, s_pmem_read, s_ld_tag, s_ld_valid, s_ld_data;
  logic        s_fill_way, s_ld_lru, s_lru_in, s_hit_way;
  logic [3:0]  s_hit_count, s_miss_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  l1icache_control #(.CNT_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .hit0(hit0), .hit1(hit1),
    .lru_out(lru_out), .pmem_resp(pmem_resp), .mem_resp(mem_resp),
    .pmem_read(pmem_read), .ld_tag(ld_tag), .ld_valid(ld_valid), .ld_data(ld_data),
    .fill_way(fill_way), .ld_lru(ld_lru), .lru_in(lru_in), .hit_way(hit_way),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  l1icache_control #(.CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .hit0(hit0), .hit1(hit1),
    .lru_out(lru_out), .pmem_resp(pmem_resp), .mem_resp(s_mem_resp),
    .pmem_read(s_pmem_read), .ld_tag(s_ld_tag), .ld_valid(s_ld_valid), .ld_data(s_ld_data),
    .fill_way(s_fill_way), .ld_lru(s_ld_lru), .lru_in(s_lru_in), .hit_way(s_hit_way),
    .hit_count(s_hit_count), .miss_count(s_miss_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are checked mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_strobes(input string tag, input logic rsp, input logic pr,
                             input logic ld, input logic lru_wr);
    #1;
    chk({tag, ".mem_resp"}, mem_resp, rsp);
    chk({tag, ".pmem_read"}, pmem_read, pr);
    chk({tag, ".ld_data"}, ld_data, ld);
    chk({tag, ".ld_tag"}, ld_tag, ld);
    chk({tag, ".ld_valid"}, ld_valid, ld);
    chk({tag, ".ld_lru"}, ld_lru, lru_wr);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    // 1. Reset then idle
    #1;
    rst_n = 1'b0;
    tick();
    tick();
    chk_strobes("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst.hit_count", hit_count, 32'd0);
    chk("rst.miss_count", miss_count, 32'd0);
    chk("rst.fill_way", fill_way, 32'd0);
    rst_n = 1'b1;
    tick();
    chk_strobes("idle", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("idle.hit_count", hit_count, 32'd0);

    // 2. Three back-to-back hits on way1
    mem_read = 1'b1;
    hit1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk_strobes("hit1", 1'b1, 1'b0, 1'b0, 1'b1);
      chk("hit1.hit_way", hit_way, 32'd1);
      chk("hit1.lru_in", lru_in, 32'd0);
      tick();
    end
    chk("hit1.hit_count", hit_count, 32'd3);
    chk("hit1.miss_count", miss_count, 32'd0);

    // Hit on way0, then the illegal double hit resolved as way0
    hit1 = 1'b0;
    hit0 = 1'b1;
    #1;
    chk("hit0.hit_way", hit_way, 32'd0);
    chk("hit0.lru_in", lru_in, 32'd1);
    chk("hit0.mem_resp", mem_resp, 32'd1);
    tick();
    hit1 = 1'b1;
    #1;
    chk("dbl.hit_way", hit_way, 32'd0);
    chk("dbl.lru_in", lru_in, 32'd1);
    tick();
    chk("dbl.hit_count", hit_count, 32'd5);
    mem_read = 1'b0;
    hit0 = 1'b0;
    hit1 = 1'b0;
    do_reset();

    // 3. Miss, victim way1, pmem_resp on the 6th fetch cycle
    mem_read = 1'b1;
    lru_out = 1'b1;
    chk_strobes("miss.det", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    lru_out = 1'b0;  // victim must already be latched
    chk("miss.fill_way", fill_way, 32'd1);
    chk("miss.miss_count", miss_count, 32'd1);
    for (int i = 0; i < 6; i++) begin
      pmem_resp = (i == 5);
      chk_strobes("miss.fetch", 1'b0, 1'b1, (i == 5), 1'b0);
      tick();
      pmem_resp = 1'b0;
    end
    hit1 = 1'b1;
    chk_strobes("miss.refill", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("miss.refill.fill_way", fill_way, 32'd1);
    tick();
    chk_strobes("miss.resp", 1'b1, 1'b0, 1'b0, 1'b1);
    chk("miss.resp.lru_in", lru_in, 32'd0);
    tick();
    chk("miss.hit_count", hit_count, 32'd1);
    chk("miss.miss_count2", miss_count, 32'd1);
    mem_read = 1'b0;
    hit1 = 1'b0;

    // 4. Flush two cycles into the fetch
    mem_read = 1'b1;
    tick();
    chk("flush.fill_way", fill_way, 32'd0);
    chk("flush.miss_count", miss_count, 32'd2);
    tick();
    tick();
    mem_read = 1'b0;
    chk_strobes("flush.fetch", 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    pmem_resp = 1'b1;
    chk_strobes("flush.resp", 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    pmem_resp = 1'b0;
    chk_strobes("flush.refill", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_strobes("flush.check", 1'b0, 1'b0, 1'b0, 1'b0);
    pmem_resp = 1'b1;  // stray response in S_CHECK
    chk_strobes("stray", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    pmem_resp = 1'b0;
    chk_strobes("stray.after", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("flush.hit_count", hit_count, 32'd1);

    // 5. Asynchronous reset in the middle of a fetch
    mem_read = 1'b1;
    tick();
    chk_strobes("arst.fetch", 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst.pmem_read", pmem_read, 32'd0);
    chk("arst.hit_count", hit_count, 32'd0);
    chk("arst.miss_count", miss_count, 32'd0);
    mem_read = 1'b0;
    tick();
    rst_n = 1'b1;
    pmem_resp = 1'b1;
    chk_strobes("arst.stray", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    pmem_resp = 1'b0;
    chk_strobes("arst.idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // 6. Saturation on the 4-bit instance: 20 hits
    do_reset();
    mem_read = 1'b1;
    hit0 = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk("sat.hit_count", s_hit_count, (i > 15) ? 32'd15 : 32'(i));
    end
    chk("sat.wide_hit_count", hit_count, 32'd20);
    chk("sat.miss_count", s_miss_count, 32'd0);
    mem_read = 1'b0;
    hit0 = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
